// File: rtl/seq_match_logger.sv
// Timestamps each sampled match pulse z, buffers the stamps in a small FIFO
// exposed as a valid/ready stream, and keeps saturating match/drop counters.
module seq_match_logger #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       z,
  input  logic                       clr,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              ovf_q, ovf_d;
  logic [TS_W-1:0]   mem_q [DEPTH];

  logic push, pop, wr_en, drop;

  // clr masks both z and the consumer handshake for its cycle.
  assign push  = z & ~clr;
  assign pop   = (state_q != StEmpty) & evt_ready & ~clr;
  assign wr_en = push & ((state_q != StFull) | pop);
  assign drop  = push & (state_q == StFull) & ~pop;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    match_cnt_d = match_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q;

    if (clr) begin
      state_d     = StEmpty;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      level_d     = '0;
      match_cnt_d = '0;
      drop_cnt_d  = '0;
      ovf_d       = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !pop)      level_d = level_q + LW'(1);
      else if (pop && !wr_en) level_d = level_q - LW'(1);

      if (push && match_cnt_q != {CNT_W{1'b1}}) match_cnt_d = match_cnt_q + CNT_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        StEmpty:   if (wr_en) state_d = StPartial;
        StPartial: begin
          if (level_d == LW'(DEPTH)) state_d = StFull;
          else if (level_d == '0)    state_d = StEmpty;
        end
        StFull:    if (pop && !wr_en) state_d = StPartial;
        default:   state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StEmpty;
      ts_q        <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      match_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + TS_W'(1);
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      match_cnt_q <= match_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage is reset so evt_ts reads zero straight out of reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign evt_valid = (state_q != StEmpty);
  assign evt_ts    = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign match_cnt = match_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign ovf       = ovf_q;

endmodule
